// File: rtl/pipe_stage_skid_reg_pkg.sv
// pipe_stage_skid_reg_pkg: default stage widths and control-field bit positions.
package pipe_stage_skid_reg_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NREG    = 32;
  localparam int DEF_RADDR_W = $clog2(DEF_NREG);
  localparam int DEF_CTRL_W  = 2;
  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWR    = 1;
endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// sat_counter: up counter that sticks at its all-ones value.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready stage register with one-entry skid, flush, bubble masking and perf counters.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NDATA   = 2,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [RADDR_W-1:0]      in_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [RADDR_W-1:0]      out_rd,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);
  localparam int EW = CTRL_W + NDATA*DATA_W + RADDR_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  state_e state_q, state_d;
  logic [EW-1:0] main_q, main_d, skid_q, skid_d, in_ent;
  logic [CTRL_W-1:0] main_ctrl;
  logic accept, drain;
  assign in_ent = {in_ctrl, in_data, in_rd};
  assign {main_ctrl, out_data, out_rd} = main_q;
  // in_ready comes only from the state flop so out_ready never reaches upstream combinationally
  assign in_ready  = state_q != TWO;
  assign out_valid = state_q == ONE || state_q == TWO;
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (accept) begin
          main_d  = in_ent;
          state_d = ONE;
        end
        ONE: begin
          main_d  = (accept && drain) ? in_ent : main_q;
          skid_d  = (accept && !drain) ? in_ent : skid_q;
          state_d = accept ? (drain ? ONE : TWO) : (drain ? EMPTY : ONE);
        end
        TWO: if (drain) begin
          main_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(out_valid & ~out_ready), .cnt(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bubble (
    .clk(clk), .reset(reset), .inc(out_ready & ~out_valid), .cnt(bubble_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed checks of handshake, skid, flush, masking, counters and async reset.
module tb_pipe_stage_skid_reg;
  import pipe_stage_skid_reg_pkg::*;
  localparam int CW = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0] in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic [4:0] in_rd, out_rd;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  int tests = 0, fails = 0;

  pipe_stage_skid_reg #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_rd(out_rd), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [31:0] v);
    return {~v, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_ctrl"}, 64'(out_ctrl), 64'd0);
    chk({tag, " out_data"}, out_data, 64'd0);
    chk({tag, " out_rd"}, 64'(out_rd), 64'd0);
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'd0);
  endtask

  initial begin
    in_valid = 0; flush = 0; out_ready = 0; in_ctrl = 0; in_data = 0; in_rd = 0;
    #1 reset = 1;
    #1 chk_reset_state("rst");
    step();
    step();
    reset = 0;
    // stream 0x11..0x14 with out_ready high once the first entry is visible
    in_valid = 1; in_data = mk(32'h11); in_rd = 5'd1;
    chk("s_in_ready0", 64'(in_ready), 64'd1);
    step();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s_valid%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("s_data%0d", i), out_data, mk(32'h11 + 32'(i)));
      chk($sformatf("s_in_ready%0d", i + 1), 64'(in_ready), 64'd1);
      if (i < 3) in_data = mk(32'h12 + 32'(i));
      else in_valid = 0;
      step();
    end
    chk("s_empty", 64'(out_valid), 64'd0);
    out_ready = 0;
    chk("s_stall", 64'(stall_cnt), 64'd0);
    chk("s_bubble", 64'(bubble_cnt), 64'd0);
    // backpressure: A0 in main, A1 in skid, A2 held upstream
    in_valid = 1; in_data = mk(32'hA0);
    step();
    in_data = mk(32'hA1);
    chk("b_in_ready1", 64'(in_ready), 64'd1);
    chk("b_data_a0", out_data, mk(32'hA0));
    step();
    in_data = mk(32'hA2);
    chk("b_in_ready2", 64'(in_ready), 64'd0);
    step();
    chk("b_in_ready3", 64'(in_ready), 64'd0);
    step();
    out_ready = 1;
    chk("b_out0", out_data, mk(32'hA0));
    chk("b_in_ready4", 64'(in_ready), 64'd0);
    chk("b_stall3", 64'(stall_cnt), 64'd3);
    step();
    chk("b_out1", out_data, mk(32'hA1));
    chk("b_in_ready5", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
    chk("b_out2", out_data, mk(32'hA2));
    chk("b_valid2", 64'(out_valid), 64'd1);
    step();
    chk("b_empty", 64'(out_valid), 64'd0);
    out_ready = 0;
    chk("b_stall_end", 64'(stall_cnt), 64'd3);
    chk("b_bubble_end", 64'(bubble_cnt), 64'd0);
    // flush while in TWO with a new entry offered
    in_valid = 1; in_data = mk(32'hB0); in_ctrl = 2'b11;
    step();
    in_data = mk(32'hB1);
    step();
    in_data = mk(32'hB2); flush = 1;
    chk("f_two", 64'(in_ready), 64'd0);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("f_valid", 64'(out_valid), 64'd0);
    chk("f_ctrl", 64'(out_ctrl), 64'd0);
    chk("f_in_ready", 64'(in_ready), 64'd1);
    chk("f_stall", 64'(stall_cnt), 64'd5);
    step();
    chk("f_gone", 64'(out_valid), 64'd0);
    chk("f_bubble", 64'(bubble_cnt), 64'd1);
    // bubble masking
    in_valid = 1; in_ctrl = 2'b11; in_data = mk(32'hC5); in_rd = 5'd17;
    step();
    in_valid = 0; in_ctrl = 2'b00;
    chk("m_ctrl_on", 64'(out_ctrl), 64'd3);
    chk("m_regwr", 64'(out_ctrl[CTRL_REGWR]), 64'd1);
    chk("m_rd", 64'(out_rd), 64'd17);
    chk("m_bubble2", 64'(bubble_cnt), 64'd2);
    step();
    chk("m_ctrl_off", 64'(out_ctrl), 64'd0);
    chk("m_memtoreg", 64'(out_ctrl[CTRL_MEMTOREG]), 64'd0);
    chk("m_bubble_hold", 64'(bubble_cnt), 64'd2);
    step();
    chk("m_bubble3", 64'(bubble_cnt), 64'd3);
    step();
    chk("m_bubble4", 64'(bubble_cnt), 64'd4);
    out_ready = 0;
    // asynchronous reset while in TWO
    in_valid = 1; in_data = mk(32'hD0); in_ctrl = 2'b11; in_rd = 5'd3;
    step();
    in_data = mk(32'hD1);
    step();
    in_valid = 0;
    chk("r_two", 64'(in_ready), 64'd0);
    #2 reset = 1;
    #1 chk_reset_state("arst");
    #1 reset = 0;
    step();
    chk("arst_after_edge", 64'(out_valid), 64'd0);
    // stall counter saturation at 3 bits
    in_valid = 1; in_data = mk(32'hE0);
    step();
    in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3 || i >= 7) chk($sformatf("sat%0d", i), 64'(stall_cnt), 64'(i < 7 ? i : 7));
    end
    chk("sat_out_data", out_data, mk(32'hE0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
